qspi_fetch_buffer: RTL



---
 rtl/qspi_fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/qspi_fetch_buffer.sv | 113 +++++++++++
 3 files changed

// File: rtl/qspi_fetch_pkg.sv
// Shared types and helpers for the QSPI instruction prefetch buffer.
package qspi_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STOP   = 2'd1,
    S_START  = 2'd2,
    S_STREAM = 2'd3
  } fetch_state_e;

  // Clears the byte-offset bits within one controller word.
  function automatic logic [31:0] align_mask(input int unsigned dw_bytes);
    return ~(32'(dw_bytes) - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular word FIFO holding prefetched instruction words.
module fetch_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/qspi_fetch_buffer.sv
// Prefetch stage: launches sequential flash reads and buffers words
// for the CPU fetch port, restarting on every redirect.
module qspi_fetch_buffer
  import qspi_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_BYTES = 2,
  parameter int unsigned ADDR_BITS        = 24,
  parameter int unsigned DEPTH            = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_BITS-1:0]          fetch_addr,
  input  logic                          fetch_restart,
  output logic [DATA_WIDTH_BYTES*8-1:0] instr_data,
  output logic [ADDR_BITS-1:0]          instr_addr,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [ADDR_BITS-1:0]          ctrl_addr,
  output logic                          ctrl_start_read,
  output logic                          ctrl_stall_read,
  output logic                          ctrl_stop_read,
  input  logic [DATA_WIDTH_BYTES*8-1:0] ctrl_data,
  input  logic                          ctrl_data_ready,
  input  logic                          ctrl_busy
);

  localparam int unsigned DW = DATA_WIDTH_BYTES * 8;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK =
    ADDR_BITS'(align_mask(DATA_WIDTH_BYTES));

  fetch_state_e         state_q, state_d;
  logic                 dr_q;
  logic [ADDR_BITS-1:0] instr_addr_q, instr_addr_d;
  logic [ADDR_BITS-1:0] ctrl_addr_q, ctrl_addr_d;
  logic [CW-1:0]        count;
  logic                 accept, pop, flush;

  always_comb begin
    state_d         = state_q;
    instr_addr_d    = instr_addr_q;
    ctrl_addr_d     = ctrl_addr_q;
    ctrl_start_read = 1'b0;
    ctrl_stop_read  = 1'b0;
    ctrl_stall_read = 1'b0;
    accept          = 1'b0;
    flush           = 1'b0;
    pop             = instr_valid && instr_ready;

    unique case (state_q)
      S_IDLE: ;
      S_STOP: begin
        ctrl_stop_read = 1'b1;
        state_d        = S_START;
      end
      S_START: begin
        ctrl_start_read = 1'b1;
        state_d         = S_STREAM;
      end
      S_STREAM: begin
        // Controller keeps data_ready high while stalled; take only the edge.
        accept          = ctrl_data_ready && !dr_q;
        ctrl_stall_read = count >= CW'(DEPTH - 1);
      end
    endcase

    if (pop) begin
      instr_addr_d = instr_addr_q + ADDR_BITS'(DATA_WIDTH_BYTES);
    end

    if (fetch_restart) begin
      flush        = 1'b1;
      pop          = 1'b0;
      accept       = 1'b0;
      instr_addr_d = fetch_addr & ALIGN_MASK;
      ctrl_addr_d  = fetch_addr & ALIGN_MASK;
      state_d      = ctrl_busy ? S_STOP : S_START;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dr_q         <= 1'b0;
      instr_addr_q <= '0;
      ctrl_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      dr_q         <= ctrl_data_ready;
      instr_addr_q <= instr_addr_d;
      ctrl_addr_q  <= ctrl_addr_d;
    end
  end

  fetch_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (accept),
    .push_data (ctrl_data),
    .pop       (pop),
    .head_data (instr_data),
    .count     (count)
  );

  assign instr_valid = (count != '0);
  assign instr_addr  = instr_addr_q;
  assign ctrl_addr   = ctrl_addr_q;

endmodule
